// File: rtl/strassen_pkg.sv
// strassen_pkg: shared constants, sign table and state encoding for the Strassen combine stage
package strassen_pkg;
  localparam int M1_IDX = 0;
  localparam int M2_IDX = 1;
  localparam int M3_IDX = 2;
  localparam int M4_IDX = 3;
  localparam int M5_IDX = 4;
  localparam int M6_IDX = 5;
  localparam int M7_IDX = 6;
  localparam int C11_IDX = 0;
  localparam int C12_IDX = 1;
  localparam int C21_IDX = 2;
  localparam int C22_IDX = 3;
  localparam logic [1:0] ADD = 2'b10;
  localparam logic [1:0] SUB = 2'b01;
  localparam logic [1:0] NOP = 2'b00;
  typedef enum logic [2:0] {IDLE, READ, DRAIN, WRITE, DONE} state_t;
  localparam logic [6:0][3:0][1:0] SIGN_TAB = {
    {NOP, NOP, NOP, ADD},
    {ADD, NOP, NOP, NOP},
    {NOP, NOP, ADD, SUB},
    {NOP, ADD, NOP, ADD},
    {ADD, NOP, ADD, NOP},
    {SUB, ADD, NOP, NOP},
    {ADD, NOP, NOP, ADD}
  };
endpackage

// File: rtl/strassen_accum.sv
// strassen_accum: four quadrant accumulators driven by the product sign table
module strassen_accum
  import strassen_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  valid,
  input  logic [2:0]            k,
  input  logic [WIDTH-1:0]      data,
  output logic [3:0][WIDTH-1:0] acc
);
  always_ff @(posedge clk) begin
    for (int q = 0; q < 4; q++) begin
      if (reset || clear) acc[q] <= '0;
      else if (valid) acc[q] <= SIGN_TAB[k][q][1] ? acc[q] + data :
                                SIGN_TAB[k][q][0] ? acc[q] - data : acc[q];
    end
  end
endmodule

// File: rtl/strassen_combine.sv
// strassen_combine: reads M1..M7, forms C11..C22 via Strassen post-additions, writes them back
module strassen_combine
  import strassen_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 4,
  parameter int M_BASE = 0,
  parameter int C_BASE = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [WIDTH-1:0]  rd_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WIDTH-1:0]  wr_data
);
  state_t state, state_n;
  logic [2:0] idx, tag_k;
  logic [1:0] widx;
  logic tag_v;
  logic [3:0][WIDTH-1:0] acc;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      idx   <= '0;
      widx  <= '0;
      tag_v <= 1'b0;
      tag_k <= '0;
    end else begin
      state <= state_n;
      idx   <= state == READ ? idx + 3'd1 : '0;
      widx  <= state == WRITE ? widx + 2'd1 : '0;
      tag_v <= state == READ;
      tag_k <= idx;
    end
  end
  always_comb begin
    state_n = state;
    state_n = state == IDLE  ? (start ? READ : IDLE) :
              state == READ  ? (idx == 3'd6 ? DRAIN : READ) :
              state == DRAIN ? WRITE :
              state == WRITE ? (widx == 2'd3 ? DONE : WRITE) : IDLE;
  end
  strassen_accum #(.WIDTH(WIDTH)) u_accum (
    .clk   (clk),
    .reset (reset),
    .clear (state == IDLE && start),
    .valid (tag_v),
    .k     (tag_k),
    .data  (rd_data),
    .acc   (acc)
  );
  assign busy    = state != IDLE;
  assign done    = state == DONE;
  assign rd_en   = state == READ;
  assign wr_en   = state == WRITE;
  assign rd_addr = rd_en ? ADDR_W'(M_BASE) + ADDR_W'(idx) : '0;
  assign wr_addr = wr_en ? ADDR_W'(C_BASE) + ADDR_W'(widx) : '0;
  assign wr_data = wr_en ? acc[widx] : '0;
endmodule

// File: tb/tb_strassen_combine.sv
// tb_strassen_combine: scoreboard bench for strassen_combine
module tb_strassen_combine;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic busy, done, rd_en, wr_en;
  logic [3:0] rd_addr, wr_addr;
  logic [31:0] rd_data = '0;
  logic [31:0] wr_data;
  logic [31:0] prod [7];
  logic [31:0] res [4];
  typedef struct {logic [3:0] a; logic [31:0] d;} wr_t;
  wr_t exp_q [$];
  int checks = 0;
  int errors = 0;
  int rd_cycles = 0;
  int done_cnt = 0;
  int overlap = 0;
  strassen_combine dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    rd_data <= rd_en ? (rd_addr < 4'd7 ? prod[rd_addr] : 32'h0) : $urandom;
    if (wr_en && wr_addr >= 4'd8 && wr_addr <= 4'd11) res[wr_addr - 4'd8] <= wr_data;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (rd_en) rd_cycles++;
    if (done) done_cnt++;
    if (rd_en && wr_en) overlap++;
    if (wr_en) begin
      if (exp_q.size() == 0) check("unexpected_write", 32'(exp_q.size()), 32'd1);
      else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", 32'(wr_addr), 32'(e.a));
        check("wr_data", wr_data, e.d);
      end
    end
  end
  task automatic push_expect();
    logic [31:0] c11, c12, c21, c22;
    c11 = prod[0] + prod[3] - prod[4] + prod[6];
    c12 = prod[2] + prod[4];
    c21 = prod[1] + prod[3];
    c22 = prod[0] - prod[1] + prod[2] + prod[5];
    exp_q.push_back('{4'd8, c11});
    exp_q.push_back('{4'd9, c12});
    exp_q.push_back('{4'd10, c21});
    exp_q.push_back('{4'd11, c22});
  endtask
  task automatic load(input logic [31:0] m0, m1, m2, m3, m4, m5, m6);
    prod = '{m0, m1, m2, m3, m4, m5, m6};
  endtask
  task automatic wait_done();
    int n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", 32'(done), 32'd1);
  endtask
  task automatic do_pass();
    push_expect();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done();
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    repeat (2) @(posedge clk);
  endtask
  initial begin
    int rd0, dn0;
    res = '{default: '0};
    load(0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_rd_en", 32'(rd_en), 0);
    check("rst_wr_en", 32'(wr_en), 0);
    check("rst_rd_addr", 32'(rd_addr), 0);
    check("rst_wr_addr", 32'(wr_addr), 0);
    check("rst_wr_data", wr_data, 0);
    #1 reset = 1'b0;
    load(1, 2, 3, 4, 5, 6, 7);
    push_expect();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      check($sformatf("busy_T+%0d", c), 32'(busy), 32'(c <= 13));
      check($sformatf("done_T+%0d", c), 32'(done), 32'(c == 13));
    end
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("res_c11", res[0], 32'd7);
    check("res_c22", res[3], 32'd8);
    load(0, 0, 0, 0, 5, 0, 0);
    do_pass();
    check("m5_c11", res[0], 32'hFFFFFFFB);
    load(32'hFFFFFFFF, 0, 0, 1, 0, 0, 0);
    do_pass();
    check("wrap_c11", res[0], 32'h0);
    check("wrap_c22", res[3], 32'hFFFFFFFF);
    load(1, 2, 3, 4, 5, 6, 7);
    push_expect();
    push_expect();
    rd0 = rd_cycles;
    dn0 = done_cnt;
    @(posedge clk);
    #1 start = 1'b1;
    repeat (28) @(posedge clk);
    #1 start = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("hold_passes", 32'(done_cnt - dn0), 32'd2);
    check("hold_rd_cycles", 32'(rd_cycles - rd0), 32'd14);
    check("hold_queue", 32'(exp_q.size()), 32'd0);
    load(10, 20, 30, 40, 50, 60, 70);
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("mid_rd_addr", 32'(rd_addr), 32'd3);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("abort_busy", 32'(busy), 0);
    check("abort_rd_en", 32'(rd_en), 0);
    check("abort_wr_en", 32'(wr_en), 0);
    repeat (20) @(posedge clk);
    check("abort_res_c11", res[0], 32'd7);
    check("abort_res_c21", res[2], 32'd6);
    do_pass();
    check("after_abort_c22", res[3], 32'd80);
    load(1, 2, 3, 4, 5, 6, 7);
    do_pass();
    check("garbage_c12", res[1], 32'd8);
    check("rd_wr_overlap", 32'(overlap), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
